branch_resolve_unit: RTL
========================

# branch_resolve_unit

EX-stage branch resolution and redirect controller for the 5-stage pipelined RV32I core. It sits directly downstream of `branch_comparator`:
- drives the comparator's `brun_en`;
- consumes its `breq_flag`/`brlt_flag`, together with the decoded control-transfer type;
- computes the target, issues a registered PC redirect to IF, and flushes the IF/ID and ID/EX registers.

The redirect is held across cache-miss stalls until IF accepts it. The block also keeps resolution counters.

## Interface
Parameters:
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clk` in 1: core clock; everything is rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_branch` in 1: EX instruction is a conditional branch.
- `ex_jal` in 1: EX instruction is JAL.
- `ex_jalr` in 1: EX instruction is JALR.
- `ex_funct3` in 3: branch funct3.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_imm` in 32: sign-extended immediate.
- `ex_rs1` in 32: forwarded rs1 value.
- `breq_flag` in 1: from comparator.
- `brlt_flag` in 1: from comparator.
- `bge_flag` in 1: from comparator; unused.
- `stall` in 1: pipeline frozen by cache miss. A redirect is not accepted while high.
- `brun_en` out 1: comparator unsigned-compare select.
- `redirect_valid` out 1: PC redirect pending.
- `redirect_pc` out 32: redirect target.
- `target_misaligned` out 1: redirect target has bit 1 set.
- `flush_ifid` out 1: squash the IF/ID register.
- `flush_idex` out 1: squash the ID/EX register.
- `br_count` out CNT_W: conditional branches resolved.
- `redir_count` out CNT_W: redirects accepted.

## Operation
- `brun_en = ex_funct3[1]`. This is combinational and unsigned for BLTU/BGEU.
- Condition by funct3:
  - BEQ 000: `breq`.
  - BNE 001: `!breq`.
  - BLT 100 / BLTU 110: `brlt`.
  - BGE 101 / BGEU 111: `!brlt`.
  - 010/011: not taken.
- GE is always derived as `!brlt_flag`. `bge_flag` is not asserted for every GE case and must not be used.
- Targets:
  - Branch/JAL: `ex_pc + ex_imm`, mod 2^32.
  - JALR: `(ex_rs1 + ex_imm) & ~32'h1`.
- `resolve = ex_valid && !stall && state==IDLE`.
- `take = resolve && (ex_jal || ex_jalr || (ex_branch && cond))`.
- If more than one of `ex_branch`/`ex_jal`/`ex_jalr` is set, priority is JALR > JAL > branch.
- FSM:
  - IDLE:
    - On `take`: latch the target into `redirect_pc`, set `target_misaligned = target[1]`, and go to REDIR.
    - Otherwise stay in IDLE.
  - REDIR:
    - Outputs `redirect_valid=1`, `flush_ifid=1`, `flush_idex=1`.
    - EX inputs are ignored; the instruction in EX is wrong-path.
    - If `stall=1`: hold the state and all outputs unchanged.
    - If `stall=0`: the redirect is accepted and the FSM returns to IDLE next edge.
- `flush_*` and `redirect_valid` are asserted only in REDIR.
- A misaligned target still redirects. `target_misaligned` is informational for the trap logic.
- Counters:
  - `br_count` increments on `resolve && ex_branch && !ex_jal && !ex_jalr`, taken or not.
  - `redir_count` increments on REDIR with `!stall`.
  - Both wrap at 2^CNT_W.

## Timing
- Reset (async, `rst_n=0`):
  - FSM → IDLE.
  - `redirect_valid`, `flush_ifid`, `flush_idex`, `target_misaligned` = 0.
  - `redirect_pc` = 0, `br_count` = 0, `redir_count` = 0.
  - Reset mid-REDIR drops the redirect immediately.
- Latency:
  - Decision at edge N.
  - `redirect_valid` high in cycle N+1.
  - IF fetches the target at edge N+2.
  - Taken-branch penalty is 2 cycles with no stall.
- With `stall` high during REDIR, the redirect persists for k+1 cycles, where k is the number of stalled cycles.
- A stall in IDLE defers resolution. The frozen EX instruction resolves in the first non-stalled cycle, and is resolved exactly once.
- Back-to-back branches: the EX instruction in the REDIR cycle is never resolved or counted.

## Structure
- Shared `riscv_pkg`:
  - funct3 constants (`F3_BEQ`…`F3_BGEU`);
  - FSM state encoding (`BR_IDLE`, `BR_REDIR`).
- One combinational sub-module, `branch_cond_eval`: funct3 + flags → `cond`, `brun_en`.
- Target adders, FSM and counters live in `branch_resolve_unit`.

## Test plan
- BEQ, A=B=5, pc=0x100, imm=0x20:
  - one cycle later `redirect_valid=1`, `redirect_pc=0x120`, both flushes=1 for 1 cycle;
  - `br_count=1`, `redir_count=1`.
- Signed vs unsigned on the same operands, A=1, B=0xFFFFFFFF:
  - BGE: `brun_en=0`, taken.
  - BGEU: `brun_en=1`, `brlt=1`, not taken; no redirect, `br_count` still increments.
- JALR, rs1=0x1003, imm=4:
  - `redirect_pc=0x1006`, `target_misaligned=1`;
  - `br_count` unchanged.
- Taken BNE followed by `stall=1` for 3 cycles during REDIR:
  - `redirect_valid`/flushes held for 4 cycles with a constant `redirect_pc`;
  - `redir_count` increments once;
  - the following EX instruction is not counted.
- Assert `rst_n=0` asynchronously mid-REDIR:
  - all outputs 0 before the next clock edge;
  - after release, FSM is in IDLE and the counters are 0.
- funct3=010 with `ex_branch=1`: no redirect, `br_count+1`. Preload `br_count` to 2^CNT_W−1, then resolve a branch: the counter wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the EX-stage branch logic: funct3 codes
// and the redirect FSM state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_REDIR = 1'b1
  } br_state_e;

endpackage : riscv_pkg

// File: rtl/branch_cond_eval.sv
// Maps a branch funct3 and the comparator flags to a taken/not-taken condition,
// and selects the comparator's signed/unsigned mode.
module branch_cond_eval
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       breq_flag,
  input  logic       brlt_flag,
  output logic       cond,
  output logic       brun_en
);

  assign brun_en = funct3[1];

  // GE is always !LT; the comparator's own GE flag is not trustworthy for every case.
  always_comb begin
    // NOTE: default first so every path assigns cond and no latch is inferred.
    cond = 1'b0;
    case (funct3)
      F3_BEQ:           cond = breq_flag;
      F3_BNE:           cond = !breq_flag;
      F3_BLT, F3_BLTU:  cond = brlt_flag;
      F3_BGE, F3_BGEU:  cond = !brlt_flag;
      default:          cond = 1'b0;
    endcase
  end

endmodule : branch_cond_eval

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: computes targets, issues a registered PC redirect
// held across stalls until IF accepts it, flushes IF/ID and ID/EX, counts events.
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             breq_flag,
  input  logic             brlt_flag,
  input  logic             bge_flag,
  input  logic             stall,
  output logic             brun_en,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             target_misaligned,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] redir_count
);

  br_state_e        state_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic             target_misaligned_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] redir_count_q;

  logic        cond;
  logic        resolve;
  logic        take;
  logic        count_branch;
  logic [31:0] pc_target;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        unused_bge;

  assign unused_bge = bge_flag;

  branch_cond_eval u_cond (
    .funct3    (ex_funct3),
    .breq_flag (breq_flag),
    .brlt_flag (brlt_flag),
    .cond      (cond),
    .brun_en   (brun_en)
  );

  assign pc_target = ex_pc + ex_imm;
  assign jalr_sum  = ex_rs1 + ex_imm;
  assign target    = ex_jalr ? {jalr_sum[31:1], 1'b0} : pc_target;

  // EX is wrong-path while a redirect is pending, so nothing resolves in REDIR.
  assign resolve      = ex_valid && !stall && (state_q == BR_IDLE);
  assign take         = resolve && (ex_jal || ex_jalr || (ex_branch && cond));
  assign count_branch = resolve && ex_branch && !ex_jal && !ex_jalr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= BR_IDLE;
      redirect_valid_q    <= 1'b0;
      redirect_pc_q       <= '0;
      target_misaligned_q <= 1'b0;
      br_count_q          <= '0;
      redir_count_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (count_branch) br_count_q <= br_count_q + CNT_W'(1);
      case (state_q)
        BR_IDLE: begin
          if (take) begin
            state_q             <= BR_REDIR;
            redirect_valid_q    <= 1'b1;
            redirect_pc_q       <= target;
            target_misaligned_q <= target[1];
          end
        end
        BR_REDIR: begin
          if (!stall) begin
            state_q          <= BR_IDLE;
            redirect_valid_q <= 1'b0;
            redir_count_q    <= redir_count_q + CNT_W'(1);
          end
        end
        default: state_q <= BR_IDLE;
      endcase
    end
  end

  assign redirect_valid    = redirect_valid_q;
  assign flush_ifid        = redirect_valid_q;
  assign flush_idex        = redirect_valid_q;
  assign redirect_pc       = redirect_pc_q;
  assign target_misaligned = target_misaligned_q;
  assign br_count          = br_count_q;
  assign redir_count       = redir_count_q;

endmodule : branch_resolve_unit
